led_blink_ctrl: RTL and testbench

Multi-channel LED blink controller for the board LED bank. It drives NUM_LEDS LEDs, each with its own runtime-selected mode (off, on, periodic blink, one-shot pulse) and period. Periods are counted in ticks from a shared prescaler, not in raw clocks. Configuration arrives over a single valid/ready write port driven by the top-level control logic.

---
 rtl/led_blink_ctrl.sv | 115 +++++++++++
 tb/tb_led_blink_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/led_blink_ctrl.sv
// Multi-channel LED blink controller: shared tick prescaler plus per-channel
// OFF / ON / BLINK / ONESHOT state, configured through a valid/ready write port.
module led_blink_ctrl #(
    parameter int CLK_FREQ = 25_000_000,
    parameter int TICK_HZ  = 1000,
    parameter int NUM_LEDS = 8,
    parameter int PERIOD_W = 16,
    localparam int CH_W    = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_chan,
    input  logic [1:0]          cfg_mode,
    input  logic [PERIOD_W-1:0] cfg_period,
    output logic                tick,
    output logic [NUM_LEDS-1:0] leds
);

    localparam int          TICK_DIV  = CLK_FREQ / TICK_HZ;
    localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_ONESHOT = 2'd3
    } mode_e;

    logic [31:0]         presc_r;
    logic                tick_r;
    logic                cfg_ready_r;
    mode_e               mode_r   [NUM_LEDS];
    logic [PERIOD_W-1:0] period_r [NUM_LEDS];
    logic [PERIOD_W-1:0] cnt_r    [NUM_LEDS];
    logic [NUM_LEDS-1:0] leds_r;
    logic                wr_s;

    // A period of 0 behaves as 1, so the count is always at its end.
    function automatic logic period_done(input logic [PERIOD_W-1:0] cnt,
                                         input logic [PERIOD_W-1:0] period);
        return (period == {PERIOD_W{1'b0}}) || (cnt >= (period - PERIOD_W'(1)));
    endfunction

    assign wr_s      = cfg_valid && cfg_ready_r;
    assign cfg_ready = cfg_ready_r;
    assign tick      = tick_r;
    assign leds      = leds_r;

    // Free-running prescaler; tick is registered one cycle after the wrap value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_r     <= 32'd0;
            tick_r      <= 1'b0;
            cfg_ready_r <= 1'b0;
        end else begin
            presc_r     <= (presc_r == TICK_LAST) ? 32'd0 : presc_r + 32'd1;
            tick_r      <= (presc_r == TICK_LAST);
            cfg_ready_r <= 1'b1;
        end
    end

    // Per-channel state; an accepted write to a channel overrides a coincident tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                mode_r[i]   <= MODE_OFF;
                period_r[i] <= {PERIOD_W{1'b0}};
                cnt_r[i]    <= {PERIOD_W{1'b0}};
            end
            leds_r <= {NUM_LEDS{1'b0}};
        end else begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (wr_s && (cfg_chan == CH_W'(i))) begin
                    mode_r[i]   <= mode_e'(cfg_mode);
                    period_r[i] <= cfg_period;
                    cnt_r[i]    <= {PERIOD_W{1'b0}};
                    leds_r[i]   <= (cfg_mode != 2'd0);
                end else if (tick_r) begin
                    case (mode_r[i])
                        MODE_OFF: begin
                            leds_r[i] <= 1'b0;
                        end
                        MODE_ON: begin
                            leds_r[i] <= 1'b1;
                        end
                        MODE_BLINK: begin
                            if (period_done(cnt_r[i], period_r[i])) begin
                                cnt_r[i]  <= {PERIOD_W{1'b0}};
                                leds_r[i] <= ~leds_r[i];
                            end else begin
                                cnt_r[i] <= cnt_r[i] + PERIOD_W'(1);
                            end
                        end
                        MODE_ONESHOT: begin
                            if (period_done(cnt_r[i], period_r[i])) begin
                                cnt_r[i]  <= {PERIOD_W{1'b0}};
                                leds_r[i] <= 1'b0;
                                mode_r[i] <= MODE_OFF;
                            end else begin
                                cnt_r[i] <= cnt_r[i] + PERIOD_W'(1);
                            end
                        end
                        default: begin
                            mode_r[i] <= MODE_OFF;
                            leds_r[i] <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Directed bench for led_blink_ctrl: edge-indexed timeline of hand-derived LED
// and tick values, checked after every clock edge following reset release.
module tb_led_blink_ctrl;

    localparam int CH_W = 3;

    logic       clk;
    logic       rst_n;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [2:0] cfg_chan;
    logic [1:0] cfg_mode;
    logic [7:0] cfg_period;
    logic       tick;
    logic [5:0] leds;

    int checks;
    int errors;
    int edge_i;
    bit chk_on;

    led_blink_ctrl #(
        .CLK_FREQ(100),
        .TICK_HZ (10),
        .NUM_LEDS(6),
        .PERIOD_W(8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_chan  (cfg_chan),
        .cfg_mode  (cfg_mode),
        .cfg_period(cfg_period),
        .tick      (tick),
        .leds      (leds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, edge_i, got, exp);
        end
    endtask

    // Edge n counts rising edges after reset release (E0 = first edge with rst_n high).
    function automatic logic [5:0] exp_leds(input int n);
        logic [5:0] e;
        e = 6'b000000;
        if (n >= 22) e[3] = (n < 40) ? 1'b1 : ((((n - 40) / 20) % 2) == 1);
        e[0] = (n >= 225 && n < 250) || (n >= 352 && n < 400) || (n >= 482);
        e[1] = (n == 402);
        e[2] = (n >= 415 && n < 420) || (n >= 430 && n < 480);
        return e;
    endfunction

    function automatic logic exp_tick(input int n);
        return (n >= 9) && (((n - 9) % 10) == 0);
    endfunction

    task automatic step();
        @(posedge clk);
        edge_i++;
        #1;
        if (chk_on) begin
            check_val("leds", 32'(leds), 32'(exp_leds(edge_i)));
            check_val("tick", 32'(tick), 32'(exp_tick(edge_i)));
        end
    endtask

    task automatic run_to(input int target);
        while (edge_i < target) step();
    endtask

    task automatic wr(input logic [2:0] ch, input logic [1:0] mode, input logic [7:0] per);
        check_val("cfg_ready_at_write", 32'(cfg_ready), 32'd1);
        cfg_valid  = 1'b1;
        cfg_chan   = ch;
        cfg_mode   = mode;
        cfg_period = per;
        step();
        cfg_valid  = 1'b0;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        edge_i     = -100;
        chk_on     = 1'b0;
        rst_n      = 1'b0;
        cfg_valid  = 1'b0;
        cfg_chan   = 3'd0;
        cfg_mode   = 2'd0;
        cfg_period = 8'd0;

        repeat (5) step();
        check_val("rst_leds", 32'(leds), 32'd0);
        check_val("rst_tick", 32'(tick), 32'd0);
        check_val("rst_ready", 32'(cfg_ready), 32'd0);

        rst_n  = 1'b1;
        edge_i = -1;
        chk_on = 1'b1;
        step();
        check_val("ready_after_release", 32'(cfg_ready), 32'd1);

        // BLINK ch3 period 2, accepted at E22
        run_to(21);
        wr(3'd3, 2'd2, 8'd2);
        check_val("blink_first", 32'(leds), 32'h08);

        // ONESHOT ch0 period 3 at E225, falls at E250
        run_to(224);
        wr(3'd0, 2'd3, 8'd3);

        // Second ONESHOT at E352, restarted at E375, falls at E400
        run_to(351);
        wr(3'd0, 2'd3, 8'd3);
        run_to(374);
        wr(3'd0, 2'd3, 8'd3);

        // ON, OFF, then write to a nonexistent channel
        run_to(401);
        wr(3'd1, 2'd1, 8'd0);
        check_val("ch1_on", 32'(leds[1]), 32'd1);
        wr(3'd1, 2'd0, 8'd0);
        check_val("ch1_off", 32'(leds[1]), 32'd0);
        wr(3'd7, 2'd2, 8'd5);
        check_val("ch7_ignored", 32'(leds), 32'h00);

        // Period 0 toggles every tick; rewrite coincides with the E440 tick
        run_to(414);
        wr(3'd2, 2'd2, 8'd0);
        run_to(439);
        check_val("tick_before_rewrite", 32'(tick), 32'd1);
        wr(3'd2, 2'd2, 8'd4);
        check_val("rewrite_wins_ch3_ticks", 32'(leds), 32'h04);

        // Mid-operation reset with ch3 blinking and ch0 in ONESHOT
        run_to(481);
        wr(3'd0, 2'd3, 8'd3);
        run_to(484);
        chk_on = 1'b0;
        rst_n  = 1'b0;
        step();
        check_val("midrst_leds", 32'(leds), 32'd0);
        check_val("midrst_tick", 32'(tick), 32'd0);
        check_val("midrst_ready", 32'(cfg_ready), 32'd0);
        rst_n = 1'b1;
        repeat (100) begin
            step();
            check_val("post_rst_leds", 32'(leds), 32'd0);
        end
        check_val("post_rst_ready", 32'(cfg_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
